// File: rtl/fib_pkg.sv
// fib_pkg: shared widths and state type for the Fibonacci index search.
//   DATA_W  - width of the input value and of the dout/rem outputs
//   IDX_MAX - largest index reachable for a DATA_W-bit input (F(24)=46368)
//   IDX_W   - width of the index counter k
//   SUM_W   - width of nxt and the running sum (F(25)=75025 needs 17 bits)
package fib_pkg;

   localparam int DATA_W  = 16;
   localparam int IDX_MAX = 24;
   localparam int IDX_W   = $clog2(IDX_MAX + 1);
   localparam int SUM_W   = DATA_W + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } fib_idx_state_t;

endpackage

// File: rtl/fibonacci_index_if.sv
// fibonacci_index_if: request/result bundle for fibonacci_index.
//   start, din          - request and value to invert (master -> slave)
//   dout, exact         - registered result index and exact-match flag
//   busy, done          - search-in-progress level and result-valid pulse
//   rem (FIB_INDEX_REM_EN only) - din_latched - F(dout)
interface fibonacci_index_if;
   import fib_pkg::*;

   logic              start;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic              exact;
   logic              busy;
   logic              done;
`ifdef FIB_INDEX_REM_EN
   logic [DATA_W-1:0] rem;
`endif

   modport master (
      output start, din,
`ifdef FIB_INDEX_REM_EN
      input  rem,
`endif
      input  dout, exact, busy, done
   );

   modport slave (
      input  start, din,
`ifdef FIB_INDEX_REM_EN
      output rem,
`endif
      output dout, exact, busy, done
   );

endinterface

// File: rtl/fib_seq_step.sv
// fib_seq_step: Fibonacci sequence stepper.
//   clk, reset - clock, asynchronous active-high reset
//   load_i     - restart at k=1, cur=F(1)=1, nxt=F(2)=1
//   adv_i      - step one index: k+1, cur<=nxt, nxt<=cur+nxt
//   cur_o      - F(k)
//   nxt_o      - F(k+1), 17 bits so F(25) does not wrap
//   k_o        - current index
//   sum_o      - cur+nxt, 17 bits
module fib_seq_step
   import fib_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             adv_i,
   output logic [DATA_W-1:0] cur_o,
   output logic [SUM_W-1:0]  nxt_o,
   output logic [IDX_W-1:0]  k_o,
   output logic [SUM_W-1:0]  sum_o
);

   logic [DATA_W-1:0] cur_q;
   logic [SUM_W-1:0]  nxt_q;
   logic [IDX_W-1:0]  k_q;

   assign sum_o = {1'b0, cur_q} + nxt_q;

   // Advance only happens while nxt <= din_latched, so nxt fits in
   // DATA_W bits whenever it is moved into cur.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_q <= '0;
         nxt_q <= '0;
         k_q   <= '0;
      end else if (load_i) begin
         cur_q <= DATA_W'(1);
         nxt_q <= SUM_W'(1);
         k_q   <= IDX_W'(1);
      end else if (adv_i) begin
         cur_q <= nxt_q[DATA_W-1:0];
         nxt_q <= sum_o;
         k_q   <= k_q + IDX_W'(1);
      end
   end

   assign cur_o = cur_q;
   assign nxt_o = nxt_q;
   assign k_o   = k_q;

endmodule

// File: rtl/fibonacci_index.sv
// fibonacci_index: finds the largest n with F(n) <= din (F(0)=0, F(1)=F(2)=1).
//   clk, reset - clock, asynchronous active-high reset
//   bus        - fibonacci_index_if.slave: start/din request, dout/exact
//                result, busy level, done one-cycle pulse
// Optional macro FIB_INDEX_REM_EN adds bus.rem = din_latched - F(dout).
//
// state  | meaning
// IDLE   | waiting for start; din=0 answers immediately
// SEARCH | stepping F(k) until F(k+1) exceeds the latched value
// DONE   | one-cycle done pulse, results already registered
module fibonacci_index
   import fib_pkg::*;
(
   input  logic clk,
   input  logic reset,
   fibonacci_index_if.slave bus
);

   fib_idx_state_t    state_q, state_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              exact_q, exact_d;
   logic              busy_q, done_q;
   logic              load, adv;

   logic [DATA_W-1:0] cur;
   logic [SUM_W-1:0]  nxt;
   logic [IDX_W-1:0]  k;
   logic [SUM_W-1:0]  sum;

`ifdef FIB_INDEX_REM_EN
   logic [DATA_W-1:0] rem_q, rem_d;
`endif

   fib_seq_step u_step (
      .clk    (clk),
      .reset  (reset),
      .load_i (load),
      .adv_i  (adv),
      .cur_o  (cur),
      .nxt_o  (nxt),
      .k_o    (k),
      .sum_o  (sum)
   );

   always_comb begin
      state_d = state_q;
      din_d   = din_q;
      dout_d  = dout_q;
      exact_d = exact_q;
      load    = 1'b0;
      adv     = 1'b0;
`ifdef FIB_INDEX_REM_EN
      rem_d   = rem_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               din_d = bus.din;
               if (bus.din == '0) begin
                  dout_d  = '0;
                  exact_d = 1'b1;
`ifdef FIB_INDEX_REM_EN
                  rem_d   = '0;
`endif
                  state_d = DONE;
               end else begin
                  load    = 1'b1;
                  state_d = SEARCH;
               end
            end
         end
         SEARCH: begin
            // 17-bit compare: nxt may reach F(25)=75025.
            if (nxt <= {1'b0, din_q}) begin
               adv = 1'b1;
            end else begin
               dout_d  = {{(DATA_W-IDX_W){1'b0}}, k};
               exact_d = (cur == din_q);
`ifdef FIB_INDEX_REM_EN
               rem_d   = din_q - cur;
`endif
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         din_q   <= '0;
         dout_q  <= '0;
         exact_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef FIB_INDEX_REM_EN
         rem_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         din_q   <= din_d;
         dout_q  <= dout_d;
         exact_q <= exact_d;
         busy_q  <= (state_d == SEARCH);
         done_q  <= (state_d == DONE);
`ifdef FIB_INDEX_REM_EN
         rem_q   <= rem_d;
`endif
      end
   end

   assign bus.dout  = dout_q;
   assign bus.exact = exact_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
`ifdef FIB_INDEX_REM_EN
   assign bus.rem   = rem_q;
`endif

   // sum[16] is only ever meaningful through nxt; keep lint quiet about it.
   logic unused_sum;
   assign unused_sum = ^sum;

endmodule

// File: tb/tb_fibonacci_index.sv
// tb_fibonacci_index: directed bench for fibonacci_index.
// Covers din=0/1/4/55/65535/100/21, start re-pulse during SEARCH, and a
// mid-SEARCH reset. Build with FIB_INDEX_REM_EN to also check rem.
module tb_fibonacci_index;
   import fib_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   fibonacci_index_if bus ();

   fibonacci_index dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // One request. exp_lat is edges after the accepting edge until done.
   // When repulse is set, start is pulsed with din=7 three cycles in.
   task automatic run(input string tag, input logic [15:0] d,
                      input int exp_n, input logic exp_x, input int exp_lat,
                      input int exp_rem, input bit repulse);
      int lat, busy_cnt, extra;
      bit seen;
      @(negedge clk);
      bus.start = 1'b1;
      bus.din   = d;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.din   = ~d;
      lat = 0; busy_cnt = 0;
      seen = bus.done;
      while (!seen && lat < 40) begin
         if (bus.busy) busy_cnt++;
         if (repulse && lat == 3) begin
            bus.start = 1'b1;
            bus.din   = 16'd7;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
         seen = bus.done;
      end
      bus.start = 1'b0;
      check({tag, " done seen"}, 32'(seen), 32'd1);
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " busy cycles"}, busy_cnt, exp_lat);
      check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
      check({tag, " dout"}, 32'(bus.dout), exp_n);
      check({tag, " exact"}, 32'(bus.exact), 32'(exp_x));
`ifdef FIB_INDEX_REM_EN
      check({tag, " rem"}, 32'(bus.rem), exp_rem);
`else
      if (exp_rem < 0) $display("note: negative rem expectation in %s", tag);
`endif
      extra = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (bus.done) extra++;
      end
      check({tag, " single done"}, extra, 0);
      check({tag, " dout hold"}, 32'(bus.dout), exp_n);
      check({tag, " exact hold"}, 32'(bus.exact), 32'(exp_x));
   endtask

   initial begin
      int extra;
      bus.start = 1'b0;
      bus.din   = '0;
      reset     = 1'b1;
      #1;
      check("reset dout", 32'(bus.dout), 0);
      check("reset exact", 32'(bus.exact), 0);
      check("reset busy", 32'(bus.busy), 0);
      check("reset done", 32'(bus.done), 0);
`ifdef FIB_INDEX_REM_EN
      check("reset rem", 32'(bus.rem), 0);
`endif
      repeat (2) @(negedge clk);
      reset = 1'b0;

      //   tag        din    n   exact lat rem    repulse
      run("din4",     16'd4,     4,  1'b0, 4,  1,     1'b0);
      run("din0",     16'd0,     0,  1'b1, 0,  0,     1'b0);
      run("din55",    16'd55,    10, 1'b1, 10, 0,     1'b0);
      run("din1",     16'd1,     2,  1'b1, 2,  0,     1'b0);
      run("din65535", 16'd65535, 24, 1'b0, 24, 19167, 1'b0);
      run("din100rp", 16'd100,   11, 1'b0, 11, 11,    1'b1);

      // Reset three cycles into a din=1000 search.
      @(negedge clk);
      bus.start = 1'b1;
      bus.din   = 16'd1000;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("midrst busy before", 32'(bus.busy), 1);
      reset = 1'b1;
      #1;
      check("midrst dout", 32'(bus.dout), 0);
      check("midrst exact", 32'(bus.exact), 0);
      check("midrst busy", 32'(bus.busy), 0);
      check("midrst done", 32'(bus.done), 0);
`ifdef FIB_INDEX_REM_EN
      check("midrst rem", 32'(bus.rem), 0);
`endif
      repeat (2) @(negedge clk);
      reset = 1'b0;
      extra = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (bus.done) extra++;
      end
      check("midrst no done", extra, 0);

      run("din21",    16'd21,    8,  1'b1, 8,  0,     1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
